// File: rtl/decoder_n_to_m_seq.sv
// Registered binary-to-one-hot decoder with direct (handshaked select) and scan (rotating strobe)
// modes. Define DECODER_SEL_ERR_EN to add the sel_err output flagging out-of-range selects.
module decoder_n_to_m_seq #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned OUTS  = 4,
    parameter int unsigned DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [OUTS-1:0]  y,
    output logic             out_valid,
`ifdef DECODER_SEL_ERR_EN
    output logic             sel_err,
`endif
    output logic [SEL_W-1:0] scan_idx
);

    localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUTS - 1);

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] idx_nxt;
    logic [OUTS-1:0]  sel_dec;
    logic             in_range;

    // Codes >= OUTS match no bit, so they decode to all-zero.
    function automatic logic [OUTS-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [OUTS-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < OUTS; k++) begin
            if (s == k[SEL_W-1:0]) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Leaving scan takes priority over a select arriving the same cycle, so refuse it there.
    assign in_ready = en & ~mode & (state_q != StScan);

    always_comb begin
        sel_dec  = onehot(sel);
        in_range = |sel_dec;
        idx_nxt  = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            scan_idx  <= '0;
`ifdef DECODER_SEL_ERR_EN
            sel_err   <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef DECODER_SEL_ERR_EN
            sel_err   <= 1'b0;
`endif
            if (!en) begin
                state_q  <= StIdle;
                cnt_q    <= '0;
                y        <= '0;
                scan_idx <= '0;
            end else if (mode) begin
                if (state_q != StScan) begin
                    state_q  <= StScan;
                    cnt_q    <= '0;
                    y        <= onehot('0);
                    scan_idx <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q    <= '0;
                    scan_idx <= idx_nxt;
                    y        <= onehot(idx_nxt);
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (state_q == StScan) begin
                state_q  <= StIdle;
                cnt_q    <= '0;
                y        <= '0;
                scan_idx <= '0;
            end else if (in_valid) begin
                state_q   <= StDirect;
                y         <= sel_dec;
                out_valid <= 1'b1;
`ifdef DECODER_SEL_ERR_EN
                sel_err   <= ~in_range;
`endif
            end
        end
    end

endmodule

// File: tb/tb_decoder_n_to_m_seq.sv
// Directed bench for decoder_n_to_m_seq: a default 2-to-4 instance and a 3-bit/5-output instance
// with single-cycle dwell.
module tb_decoder_n_to_m_seq;

    logic clk;
    logic rst;

    logic       en_a, mode_a, iv_a, rdy_a, ov_a;
    logic [1:0] sel_a, idx_a;
    logic [3:0] y_a;

    logic       en_b, mode_b, iv_b, rdy_b, ov_b;
    logic [2:0] sel_b, idx_b;
    logic [4:0] y_b;
`ifdef DECODER_SEL_ERR_EN
    logic       err_a, err_b;
`endif

    int n_vec;
    int n_err;

    decoder_n_to_m_seq u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en_a),
        .mode     (mode_a),
        .in_valid (iv_a),
        .in_ready (rdy_a),
        .sel      (sel_a),
        .y        (y_a),
        .out_valid(ov_a),
`ifdef DECODER_SEL_ERR_EN
        .sel_err  (err_a),
`endif
        .scan_idx (idx_a)
    );

    decoder_n_to_m_seq #(
        .SEL_W(3),
        .OUTS (5),
        .DWELL(1)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en_b),
        .mode     (mode_b),
        .in_valid (iv_b),
        .in_ready (rdy_b),
        .sel      (sel_b),
        .y        (y_b),
        .out_valid(ov_b),
`ifdef DECODER_SEL_ERR_EN
        .sel_err  (err_b),
`endif
        .scan_idx (idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic       iv;
        logic [1:0] sel;
        logic       rdy;
        logic [3:0] y;
        logic       ov;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // en mode iv sel | ready y ov idx
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0001, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd0};

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        en_a = 1'b0; mode_a = 1'b0; iv_a = 1'b0; sel_a = '0;
        en_b = 1'b0; mode_b = 1'b0; iv_b = 1'b0; sel_b = '0;

        // Reset state
        tick();
        check("rst_y", 32'(y_a), 32'd0);
        check("rst_ov", 32'(ov_a), 32'd0);
        check("rst_idx", 32'(idx_a), 32'd0);
        check("rst_ready", 32'(rdy_a), 32'd0);
        rst = 1'b0;
        tick();

        // Direct mode, en gating and scan-exit vectors
        for (int i = 0; i < 11; i++) begin
            en_a = tbl[i].en; mode_a = tbl[i].mode; iv_a = tbl[i].iv; sel_a = tbl[i].sel;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(rdy_a), 32'(tbl[i].rdy));
            tick();
            check($sformatf("tbl%0d_y", i), 32'(y_a), 32'(tbl[i].y));
            check($sformatf("tbl%0d_ov", i), 32'(ov_a), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_idx", i), 32'(idx_a), 32'(tbl[i].idx));
        end

        // Scan rotation, DWELL=4: each output held four cycles, then wrap
        en_a = 1'b0; iv_a = 1'b0;
        tick();
        en_a = 1'b1; mode_a = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("scan%0d_y", c), 32'(y_a), 32'(4'b0001 << ((c / 4) % 4)));
            check($sformatf("scan%0d_idx", c), 32'(idx_a), 32'((c / 4) % 4));
        end

        // Drop mode mid-scan at index 2; a select offered that cycle is refused
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        for (int c = 0; c < 9; c++) tick();
        check("mid_idx", 32'(idx_a), 32'd2);
        mode_a = 1'b0; iv_a = 1'b1; sel_a = 2'd1;
        #1;
        check("exit_ready", 32'(rdy_a), 32'd0);
        tick();
        check("exit_y", 32'(y_a), 32'd0);
        check("exit_ov", 32'(ov_a), 32'd0);
        check("exit_idx", 32'(idx_a), 32'd0);
        tick();
        check("after_y", 32'(y_a), 32'b0010);
        check("after_ov", 32'(ov_a), 32'd1);

        // Asynchronous reset between edges during scan
        iv_a = 1'b0; mode_a = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("prerst_idx", 32'(idx_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_y", 32'(y_a), 32'd0);
        check("arst_idx", 32'(idx_a), 32'd0);
        tick();
        #3 rst = 1'b0;
        tick();
        check("restart_y", 32'(y_a), 32'b0001);
        check("restart_idx", 32'(idx_a), 32'd0);
        for (int c = 0; c < 4; c++) tick();
        check("restart_adv_y", 32'(y_a), 32'b0010);
        check("restart_adv_idx", 32'(idx_a), 32'd1);
        en_a = 1'b0;

        // SEL_W=3, OUTS=5: out-of-range selects decode to zero
        en_b = 1'b1; mode_b = 1'b0; iv_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [2:0] s;
            logic [4:0] ey;
            logic       eov;
            case (i)
                0: begin s = 3'd6; ey = 5'b00000; eov = 1'b1; end
                1: begin s = 3'd4; ey = 5'b10000; eov = 1'b1; end
                2: begin s = 3'd5; ey = 5'b00000; eov = 1'b1; end
                3: begin s = 3'd0; ey = 5'b00001; eov = 1'b1; end
                default: begin s = 3'd7; ey = 5'b00001; eov = 1'b0; end
            endcase
            sel_b = s;
            iv_b  = (i != 4);
            tick();
            check($sformatf("b%0d_y", i), 32'(y_b), 32'(ey));
            check($sformatf("b%0d_ov", i), 32'(ov_b), 32'(eov));
`ifdef DECODER_SEL_ERR_EN
            check($sformatf("b%0d_err", i), 32'(err_b), 32'(eov && (s >= 3'd5)));
`endif
        end

        // DWELL=1 scan: advances every cycle and wraps after index 4
        mode_b = 1'b1; iv_b = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            check($sformatf("bscan%0d_y", c), 32'(y_b), 32'(5'b00001 << (c % 5)));
            check($sformatf("bscan%0d_idx", c), 32'(idx_b), 32'(c % 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
